// File: rtl/block_sync.sv
// ---------------------------------------------------------------------------
// block_sync
// 64b/66b block synchroniser. Raw 66-bit words arrive from the gearbox at an
// arbitrary bit alignment. The block locates the 2-bit sync header by slipping
// a bit offset one position at a time. Once locked, it forwards each aligned
// block downstream and watches for too many bad headers in a test window.
//
// Ports
//   rx_clk          : single clock, all state on its rising edge
//   rx_rst          : asynchronous active-low reset
//   data_in         : raw word from the gearbox
//   data_valid_in   : data_in valid
//   data_ready_out  : block accepts data_in (combinational)
//   data_out        : aligned block, [65:64] sync header, [63:0] payload
//   data_valid_out  : data_out valid
//   data_ready_in   : downstream accepts data_out
//   block_lock      : registered lock status
//   slip            : one-cycle pulse on each alignment slip
//   bit_offset      : current alignment offset, 0..65
// ---------------------------------------------------------------------------
module block_sync #(
    parameter int DATA_WIDTH   = 66,
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    output logic                  data_ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    input  logic                  data_ready_in,
    output logic                  block_lock,
    output logic                  slip,
    output logic [6:0]            bit_offset
);

    localparam logic [6:0] CNT_MAX_C   = 7'(SH_CNT_MAX);
    localparam logic [4:0] INVLD_MAX_C = 5'(SH_INVLD_MAX);
    localparam logic [6:0] OFFSET_MAX  = 7'd65;

    logic [DATA_WIDTH-1:0]   prev_word_q, prev_word_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    data_valid_out_q, data_valid_out_d;
    logic                    block_lock_q, block_lock_d;
    logic                    slip_q, slip_d;
    logic [6:0]              bit_offset_q, bit_offset_d;
    logic [6:0]              sh_cnt_q, sh_cnt_d;
    logic [4:0]              sh_invld_cnt_q, sh_invld_cnt_d;
    logic                    primed_q, primed_d;

    logic                    accept_s;
    logic [2*DATA_WIDTH-1:0] cat_s;
    logic [DATA_WIDTH-1:0]   window_s;
    logic                    sh_valid_s;
    logic [6:0]              sh_cnt_inc_s;
    logic [4:0]              sh_invld_inc_s;
    logic [6:0]              offset_next_s;

    // Handshake: a held output only blocks input while downstream is stalled.
    assign data_ready_out = data_ready_in | ~data_valid_out_q;
    assign accept_s       = data_valid_in & data_ready_out;

    // The previous word holds the older bits, so the window slides from the
    // previous word into the current one as the offset grows.
    assign cat_s          = {data_in, prev_word_q};
    assign window_s       = DATA_WIDTH'(cat_s >> bit_offset_q);
    assign sh_valid_s     = window_s[65] ^ window_s[64];
    assign sh_cnt_inc_s   = sh_cnt_q + 7'd1;
    assign sh_invld_inc_s = sh_invld_cnt_q + {4'd0, ~sh_valid_s};
    assign offset_next_s  = (bit_offset_q == OFFSET_MAX) ? 7'd0 : (bit_offset_q + 7'd1);

    // Next-state: priming, header test, lock tracking, slip and output load.
    always_comb begin
        prev_word_d      = prev_word_q;
        primed_d         = primed_q;
        block_lock_d     = block_lock_q;
        slip_d           = 1'b0;
        bit_offset_d     = bit_offset_q;
        sh_cnt_d         = sh_cnt_q;
        sh_invld_cnt_d   = sh_invld_cnt_q;
        data_out_d       = data_out_q;
        data_valid_out_d = data_valid_out_q;

        if (data_valid_out_q && data_ready_in) begin
            data_valid_out_d = 1'b0;
        end else begin
            data_valid_out_d = data_valid_out_q;
        end

        if (accept_s) begin
            prev_word_d = data_in;
            primed_d    = 1'b1;
            if (primed_q) begin
                if (block_lock_q) begin
                    // Output uses the lock state before this test updates it.
                    data_out_d       = window_s;
                    data_valid_out_d = 1'b1;
                    // Loss of lock takes priority over the window end.
                    if (sh_invld_inc_s == INVLD_MAX_C) begin
                        block_lock_d   = 1'b0;
                        slip_d         = 1'b1;
                        bit_offset_d   = offset_next_s;
                        sh_cnt_d       = 7'd0;
                        sh_invld_cnt_d = 5'd0;
                    end else if (sh_cnt_inc_s == CNT_MAX_C) begin
                        sh_cnt_d       = 7'd0;
                        sh_invld_cnt_d = 5'd0;
                    end else begin
                        sh_cnt_d       = sh_cnt_inc_s;
                        sh_invld_cnt_d = sh_invld_inc_s;
                    end
                end else begin
                    if (!sh_valid_s) begin
                        slip_d         = 1'b1;
                        bit_offset_d   = offset_next_s;
                        sh_cnt_d       = 7'd0;
                        sh_invld_cnt_d = 5'd0;
                    end else if (sh_cnt_inc_s == CNT_MAX_C) begin
                        block_lock_d   = 1'b1;
                        sh_cnt_d       = 7'd0;
                        sh_invld_cnt_d = 5'd0;
                    end else begin
                        sh_cnt_d       = sh_cnt_inc_s;
                    end
                end
            end else begin
                primed_d = 1'b1;
            end
        end else begin
            prev_word_d = prev_word_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            prev_word_q      <= {DATA_WIDTH{1'b0}};
            primed_q         <= 1'b0;
            block_lock_q     <= 1'b0;
            slip_q           <= 1'b0;
            bit_offset_q     <= 7'd0;
            sh_cnt_q         <= 7'd0;
            sh_invld_cnt_q   <= 5'd0;
            data_out_q       <= {DATA_WIDTH{1'b0}};
            data_valid_out_q <= 1'b0;
        end else begin
            prev_word_q      <= prev_word_d;
            primed_q         <= primed_d;
            block_lock_q     <= block_lock_d;
            slip_q           <= slip_d;
            bit_offset_q     <= bit_offset_d;
            sh_cnt_q         <= sh_cnt_d;
            sh_invld_cnt_q   <= sh_invld_cnt_d;
            data_out_q       <= data_out_d;
            data_valid_out_q <= data_valid_out_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_valid_out = data_valid_out_q;
    assign block_lock     = block_lock_q;
    assign slip           = slip_q;
    assign bit_offset     = bit_offset_q;

endmodule

// File: tb/tb_block_sync.sv
// ---------------------------------------------------------------------------
// tb_block_sync
// Directed bench for block_sync: reset values, aligned lock, backpressure,
// idle input, invalid-header windows, loss of lock, reset while locked,
// misaligned stream and offset wrap. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_block_sync;

    logic        rx_clk = 1'b0;
    logic        rx_rst;
    logic [65:0] data_in;
    logic        data_valid_in;
    logic        data_ready_out;
    logic [65:0] data_out;
    logic        data_valid_out;
    logic        data_ready_in;
    logic        block_lock;
    logic        slip;
    logic [6:0]  bit_offset;

    int n_checks = 0;
    int n_fail   = 0;

    block_sync dut (
        .rx_clk         (rx_clk),
        .rx_rst         (rx_rst),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .data_ready_out (data_ready_out),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .data_ready_in  (data_ready_in),
        .block_lock     (block_lock),
        .slip           (slip),
        .bit_offset     (bit_offset)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Aligned test word: header, fixed tag, index in the low bits.
    function automatic logic [65:0] wd(input logic [1:0] hdr, input int n);
        return {hdr, 32'hC0DE_0000, 32'(n)};
    endfunction

    // Block for the misaligned stream; bits 63:59 all ones so that offsets
    // 0..4 always see 11 as the header.
    function automatic logic [65:0] blk(input int j);
        return {2'b01, 5'b11111, 27'd0, 32'(j)};
    endfunction

    task automatic send(input logic [65:0] w);
        data_in       = w;
        data_valid_in = 1'b1;
        @(posedge rx_clk);
        #1;
    endtask

    task automatic do_reset();
        data_valid_in = 1'b0;
        #2;
        rx_rst = 1'b0;
        @(posedge rx_clk);
        #1;
        rx_rst = 1'b1;
    endtask

    task automatic relock(input string tag);
        for (int n = 0; n <= 65; n++) begin
            send(wd(2'b01, n));
            if (n == 63) chk({tag, "_lock_at_63"}, 66'(block_lock), 66'd0);
            if (n == 64) begin
                chk({tag, "_lock_at_64"}, 66'(block_lock), 66'd1);
                chk({tag, "_novalid_at_64"}, 66'(data_valid_out), 66'd0);
            end
        end
        chk({tag, "_first_valid"}, 66'(data_valid_out), 66'd1);
        chk({tag, "_first_data"}, data_out, wd(2'b01, 64));
    endtask

    initial begin
        int          slip_cnt;
        int          saw_valid;
        logic [65:0] bc;
        logic [65:0] bp;

        rx_rst        = 1'b0;
        data_in       = 66'd0;
        data_valid_in = 1'b0;
        data_ready_in = 1'b1;
        #3;
        chk("rst_data_out", data_out, 66'd0);
        chk("rst_valid", 66'(data_valid_out), 66'd0);
        chk("rst_lock", 66'(block_lock), 66'd0);
        chk("rst_slip", 66'(slip), 66'd0);
        chk("rst_offset", 66'(bit_offset), 66'd0);
        chk("rst_ready_out", 66'(data_ready_out), 66'd1);
        @(posedge rx_clk);
        #1;
        rx_rst = 1'b1;

        // Aligned lock: priming + 64 tests, output one word later.
        relock("lock1");

        // Backpressure for 3 cycles with a pending input word.
        data_ready_in = 1'b0;
        data_in       = wd(2'b01, 66);
        data_valid_in = 1'b1;
        #1;
        chk("bp_ready_out_low", 66'(data_ready_out), 66'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge rx_clk);
            #1;
            chk("bp_data_held", data_out, wd(2'b01, 64));
            chk("bp_valid_held", 66'(data_valid_out), 66'd1);
        end
        data_ready_in = 1'b1;
        #1;
        chk("bp_ready_out_high", 66'(data_ready_out), 66'd1);
        @(posedge rx_clk);
        #1;
        chk("bp_next_data", data_out, wd(2'b01, 65));
        send(wd(2'b01, 67));
        chk("bp_after_data", data_out, wd(2'b01, 66));

        // Idle input: output drains, no state change.
        data_valid_in = 1'b0;
        repeat (2) begin
            @(posedge rx_clk);
            #1;
        end
        chk("idle_valid_clear", 66'(data_valid_out), 66'd0);
        chk("idle_lock", 66'(block_lock), 66'd1);
        chk("idle_data_held", data_out, wd(2'b01, 66));
        chk("idle_offset", 66'(bit_offset), 66'd0);

        // Window 2 (tests on words 65..128): 15 invalid headers, lock holds.
        for (int n = 68; n <= 128; n++) begin
            send(wd((n >= 70 && n <= 84) ? 2'b00 : 2'b01, n));
        end
        chk("win15_lock_holds", 66'(block_lock), 66'd1);
        chk("win15_data", data_out, wd(2'b01, 127));

        // Window 3: 15 invalid so far keeps lock; the 16th drops it.
        for (int n = 129; n <= 145; n++) begin
            send(wd((n >= 130) ? 2'b00 : 2'b01, n));
        end
        chk("win16_lock_at_15", 66'(block_lock), 66'd1);
        send(wd(2'b01, 146));
        chk("win16_lock_lost", 66'(block_lock), 66'd0);
        chk("win16_slip", 66'(slip), 66'd1);
        chk("win16_offset", 66'(bit_offset), 66'd1);
        chk("win16_last_valid", 66'(data_valid_out), 66'd1);
        chk("win16_last_data", data_out, wd(2'b00, 145));
        send(wd(2'b01, 147));
        chk("post_loss_slip_pulse", 66'(slip), 66'd0);
        chk("post_loss_no_output", 66'(data_valid_out), 66'd0);
        chk("post_loss_offset", 66'(bit_offset), 66'd1);

        // Reset mid-window, then relock needs a full 64 headers.
        do_reset();
        chk("rst2_offset", 66'(bit_offset), 66'd0);
        for (int n = 0; n < 40; n++) send(wd(2'b01, n));
        do_reset();
        relock("lock2");

        // Asynchronous reset while locked, checked between clock edges.
        #2;
        rx_rst = 1'b0;
        #1;
        chk("async_data_out", data_out, 66'd0);
        chk("async_valid", 66'(data_valid_out), 66'd0);
        chk("async_lock", 66'(block_lock), 66'd0);
        chk("async_offset", 66'(bit_offset), 66'd0);
        @(posedge rx_clk);
        #1;
        rx_rst = 1'b1;

        // Stream misaligned by 5 bits.
        slip_cnt  = 0;
        saw_valid = 0;
        for (int t = 0; t <= 69; t++) begin
            bc = blk(t);
            bp = blk(t - 1);
            send({bc[60:0], bp[65:61]});
            if (slip) slip_cnt++;
            if (data_valid_out) saw_valid++;
            if (t == 68) chk("mis_lock_at_68", 66'(block_lock), 66'd0);
        end
        chk("mis_slip_count", 66'(slip_cnt), 66'd5);
        chk("mis_offset", 66'(bit_offset), 66'd5);
        chk("mis_lock", 66'(block_lock), 66'd1);
        chk("mis_no_early_output", 66'(saw_valid), 66'd0);
        bc = blk(70);
        bp = blk(69);
        send({bc[60:0], bp[65:61]});
        chk("mis_data", data_out, blk(69));
        chk("mis_valid", 66'(data_valid_out), 66'd1);

        // Offset wrap: all-zero words slip on every test.
        do_reset();
        for (int t = 0; t <= 65; t++) send(66'd0);
        chk("wrap_offset_65", 66'(bit_offset), 66'd65);
        send(66'd0);
        chk("wrap_offset_0", 66'(bit_offset), 66'd0);
        chk("wrap_slip", 66'(slip), 66'd1);
        chk("wrap_lock", 66'(block_lock), 66'd0);

        data_valid_in = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_sync.md
BLOCK_SYNC -- requirements
Module: block_sync

Interface
REQ-001 Parameters: DATA_WIDTH, 66, width of raw and aligned words; fixed at 66.
REQ-002 Parameters: SH_CNT_MAX, 64, sync headers per test window.
REQ-003 Parameters: SH_INVLD_MAX, 16, invalid headers per window that cause loss of lock.
REQ-004 Ports: rx_clk, input, 1, the block's single clock; all state on its rising edge.
REQ-005 Ports: rx_rst, input, 1, asynchronous active-low reset.
REQ-006 Ports: data_in, input, 66, raw word from gearbox; arbitrary bit alignment.
REQ-007 Ports: data_valid_in, input, 1, data_in valid.
REQ-008 Ports: data_ready_out, output, 1, block accepts data_in.
REQ-009 Ports: data_out, output, 66, aligned block; [65:64] sync header, [63:0] payload.
REQ-010 Ports: data_valid_out, output, 1, data_out valid.
REQ-011 Ports: data_ready_in, input, 1, downstream (descrambler) accepts data_out.
REQ-012 Ports: block_lock, output, 1, registered lock status.
REQ-013 Ports: slip, output, 1, one-cycle pulse on each alignment slip.
REQ-014 Ports: bit_offset, output, 7, current alignment offset, range 0..65.

Function
REQ-015 Accept: data_ready_out = data_ready_in OR NOT data_valid_out (combinational); accept = data_valid_in AND data_ready_out.
REQ-016 On accept: prev_word <= data_in; window = {data_in, prev_word}[bit_offset+65 : bit_offset].
REQ-017 First accept after reset only primes prev_word (primed <= 1): no header test, no output.
REQ-018 Header test per accepted primed word: sh_valid = window[65] XOR window[64] (01, 10 valid; 00, 11 invalid).
REQ-019 Counters: sh_cnt 7-bit, 0..64; sh_invld_cnt 5-bit, 0..16; both change only on tested words.
REQ-020 Unlocked, sh_valid: sh_cnt+1; when it reaches SH_CNT_MAX, block_lock <= 1 and both counters clear.
REQ-021 Unlocked, invalid header: slip; both counters clear; block_lock stays 0.
REQ-022 Locked: sh_cnt+1 each test; an invalid header also increments sh_invld_cnt.
REQ-023 Locked: when sh_invld_cnt reaches SH_INVLD_MAX, block_lock <= 0, slip, both counters clear.
REQ-024 Locked: when sh_cnt reaches SH_CNT_MAX with sh_invld_cnt < 16, both counters clear and lock holds.
REQ-025 Simultaneous 64th header and 16th invalid in the same test: loss of lock wins.
REQ-026 Slip: bit_offset <= (bit_offset==65) ? 0 : bit_offset+1; slip=1 for exactly that cycle; new offset applies from the next accepted word.
REQ-027 Output: on a tested word with block_lock==1 (value before update), data_out <= window and data_valid_out <= 1 in the next cycle (1-cycle latency).
REQ-028 Tested word with block_lock==0 produces no output.
REQ-029 data_valid_out clears when data_ready_in=1 and no new output is loaded; while data_ready_in=0 data_out/data_valid_out hold stable.
REQ-030 Accept with no data_valid_in: no state change.

Reset
REQ-031 rx_rst low asynchronously sets: data_out=0, data_valid_out=0, block_lock=0, slip=0, bit_offset=0, sh_cnt=0, sh_invld_cnt=0, primed=0, prev_word=0.
REQ-032 Reset mid-window discards all counts; relock requires a full 64 valid headers after priming.

Verification
REQ-033 Aligned stream (offset 0, header 01 every word), ready=1 -> block_lock=1 after priming word + 64 tested words; first data_valid_out one cycle after the 65th tested word.
REQ-034 Stream misaligned by 5 bits -> slip pulses until bit_offset=5, then lock after 64 consecutive valid headers; no output before lock.
REQ-035 Locked, inject 15 invalid headers within one 64-window -> lock holds, counters clear at window end; 16 within one window -> block_lock=0, slip=1, bit_offset+1.
REQ-036 Locked, data_ready_in=0 for 3 cycles -> data_ready_out=0, data_out held, no words lost or duplicated after release.
REQ-037 bit_offset=65 with invalid header -> bit_offset wraps to 0.
REQ-038 rx_rst asserted while locked mid-transfer -> all outputs 0 immediately without a clock edge; relock sequence as REQ-033.
